// File: rtl/ram_out_streamer_pkg.sv
// Shared types and helpers for the ram_out read-side streamer.
package ram_out_streamer_pkg;

  // Pixel width of the ram_out frame buffer.
  localparam int unsigned PixW = 8;

  // Readout sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Address width for a buffer of n entries; never narrower than 1 bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_out_streamer_if.sv
// RAM read port plus output pixel stream of the ram_out streamer.
// With RAM_OUT_EOL_EN defined the stream also carries an end-of-line flag.
interface ram_out_streamer_if #(
  parameter int unsigned AddrW = 12
);
  import ram_out_streamer_pkg::*;

  logic [AddrW-1:0] rd_addr;
  logic [PixW-1:0]  rd_data;
  logic             m_valid;
  logic             m_ready;
  logic [PixW-1:0]  m_data;
`ifdef RAM_OUT_EOL_EN
  logic             m_eol;

  // Streamer side: drives the RAM address and the output stream.
  modport master (
    output rd_addr, input rd_data,
    output m_valid, input m_ready, output m_data, output m_eol
  );

  // RAM and downstream side.
  modport slave (
    input rd_addr, output rd_data,
    input m_valid, output m_ready, input m_data, input m_eol
  );
`else
  // Streamer side: drives the RAM address and the output stream.
  modport master (
    output rd_addr, input rd_data,
    output m_valid, input m_ready, output m_data
  );

  // RAM and downstream side.
  modport slave (
    input rd_addr, output rd_data,
    input m_valid, output m_ready, input m_data
  );
`endif

endinterface

// File: rtl/ram_out_streamer_pix_fifo.sv
// Small synchronous FIFO buffering pixels behind the RAM read latency.
// Depth must be a power of two so the pointers wrap naturally.
module ram_out_streamer_pix_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [DataW-1:0] push_data,
  input  logic             pop,
  output logic [DataW-1:0] pop_data,
  output logic [CntW-1:0]  count,
  output logic             empty,
  output logic             full
);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_en;
  logic             pop_en;

  // Pops from an empty FIFO are dropped; a push into a full FIFO is only
  // accepted when a pop frees the slot in the same cycle.
  always_comb begin
    pop_en  = pop && !empty;
    push_en = push && (!full || pop_en);
  end

  // Storage array; contents need no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_en) - CntW'(pop_en);
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));

endmodule

// File: rtl/ram_out_streamer.sv
// Read-side sequencer for the ram_out frame buffer: on start, reads every pixel
// once in address order and streams it out over valid/ready, hiding the
// 1-cycle registered RAM read behind a small FIFO.
// Optional feature macro: RAM_OUT_EOL_EN adds an end-of-line flag per pixel.
module ram_out_streamer
  import ram_out_streamer_pkg::*;
#(
  parameter int unsigned W          = 64,
  parameter int unsigned H          = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  ram_out_streamer_if.master  bus
);

  localparam int unsigned TotalPixel = W * H;
  localparam int unsigned AddrW      = addr_width(TotalPixel);
  localparam int unsigned PixCntW    = AddrW + 1;
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SumW       = CntW + 1;
`ifdef RAM_OUT_EOL_EN
  localparam int unsigned FifoW      = PixW + 1;
  localparam int unsigned ColW       = addr_width(W);
`else
  localparam int unsigned FifoW      = PixW;
`endif

  state_e             state_q;
  logic [AddrW-1:0]   rd_addr_q;
  logic               rd_valid_q;  // rd_data carries a read issued last cycle
  logic [1:0]         inflight_q;
  logic [PixCntW-1:0] pix_cnt_q;
  logic [PixCntW-1:0] pix_cnt_d;
`ifdef RAM_OUT_EOL_EN
  logic [ColW-1:0]    col_q;
`endif

  logic [CntW-1:0]    fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [FifoW-1:0]   fifo_wdata;
  logic [FifoW-1:0]   fifo_rdata;
  logic [SumW-1:0]    occupancy;
  logic               issue;
  logic               push;
  logic               transfer;
  logic               last_addr;

  // Issue control: reserve FIFO space for every read still in flight so a
  // returning pixel always finds a free slot.
  always_comb begin
    occupancy = SumW'(fifo_count) + SumW'(inflight_q);
    last_addr = (rd_addr_q == AddrW'(TotalPixel - 1));
    issue     = (state_q == StRead) && !fifo_full && (occupancy < SumW'(FIFO_DEPTH));
    push      = rd_valid_q;
    transfer  = bus.m_valid && bus.m_ready;
    pix_cnt_d = pix_cnt_q + PixCntW'(transfer);
  end

  // Sequencer FSM with read address, in-flight tracking and beat counting.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      // abort flushes everything, including the read returning this cycle.
      state_q    <= StIdle;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      inflight_q <= '0;
      pix_cnt_q  <= '0;
`ifdef RAM_OUT_EOL_EN
      col_q      <= '0;
`endif
    end else begin
      rd_valid_q <= issue;
      inflight_q <= inflight_q + 2'(issue) - 2'(push);
      pix_cnt_q  <= pix_cnt_d;
      if (issue && !last_addr) begin
        rd_addr_q <= rd_addr_q + AddrW'(1);
      end
`ifdef RAM_OUT_EOL_EN
      if (push) begin
        col_q <= (col_q == ColW'(W - 1)) ? '0 : col_q + ColW'(1);
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StRead;
            rd_addr_q <= '0;
            pix_cnt_q <= '0;
`ifdef RAM_OUT_EOL_EN
            col_q     <= '0;
`endif
          end
        end
        StRead: begin
          if (issue && last_addr) state_q <= StDrain;
        end
        StDrain: begin
          if (pix_cnt_d == PixCntW'(TotalPixel)) state_q <= StDone;
        end
        StDone: begin
          state_q   <= StIdle;
          rd_addr_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RAM_OUT_EOL_EN
  assign fifo_wdata = {(col_q == ColW'(W - 1)), bus.rd_data};
`else
  assign fifo_wdata = bus.rd_data;
`endif

  ram_out_streamer_pix_fifo #(
    .Depth (FIFO_DEPTH),
    .DataW (FifoW)
  ) u_pix_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (push),
    .push_data (fifo_wdata),
    .pop       (transfer),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign busy        = (state_q == StRead) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign bus.rd_addr = rd_addr_q;
  assign bus.m_valid = !fifo_empty;
  // Drive zero rather than stale storage while the FIFO is empty.
  assign bus.m_data  = fifo_empty ? '0 : fifo_rdata[PixW-1:0];
`ifdef RAM_OUT_EOL_EN
  assign bus.m_eol   = !fifo_empty && fifo_rdata[PixW];
`endif

endmodule
